// File: rtl/branch_resolve_unit.sv
// Resolves executed branches/jumps, drives predictor update, fetch redirect, and perf counters.
// Latency: every output for an accepted resolution appears one cycle after the accepting edge.
// Backpressure: freeze blocks acceptance and stalls the wrong-path squash countdown; no ready output.
module branch_resolve_unit #(
   parameter int WORD_W        = 32,
   parameter int SHADOW_CYCLES = 2,
   parameter int CNT_W         = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ex_valid,
   input  logic              ex_is_jump,
   input  logic [WORD_W-1:0] ex_pc,
   input  logic [WORD_W-1:0] ex_target,
   input  logic              ex_taken,
   input  logic              ex_pred_taken,
   input  logic [WORD_W-1:0] ex_pred_pc,
   input  logic              freeze,
   output logic              update_btb,
   output logic              branch_outcome,
   output logic              predicted_outcome,
   output logic [WORD_W-1:0] update_pc,
   output logic [WORD_W-1:0] branch_target,
   output logic              misprediction,
   output logic [WORD_W-1:0] correct_pc,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispred_cnt
);

   typedef enum logic {ST_RUN = 1'b0, ST_SHADOW = 1'b1} state_t;

   localparam logic [3:0] SHADOW_LOAD = 4'(SHADOW_CYCLES);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_shadow_cnt;
   logic [3:0]        w_shadow_cnt_nxt;

   logic              w_accept;
   logic              w_actual_taken;
   logic [WORD_W-1:0] w_seq_pc;
   logic [WORD_W-1:0] w_actual_next;
   logic              w_mispredict;

   // Wrong-path instructions following a redirect are squashed while in SHADOW.
   assign w_accept       = ex_valid && !freeze && (r_state == ST_RUN);
   assign w_actual_taken = ex_is_jump | ex_taken;
   // Sequential PC wraps naturally at the bus width.
   assign w_seq_pc       = ex_pc + WORD_W'(4);
   assign w_actual_next  = w_actual_taken ? ex_target : w_seq_pc;
   // A right direction with a wrong target still fetched the wrong path.
   assign w_mispredict   = (w_actual_next != ex_pred_pc);

   // State and squash-window counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state      <= ST_RUN;
         r_shadow_cnt <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_shadow_cnt <= w_shadow_cnt_nxt;
      end
   end

   // Next-state: enter SHADOW on an accepted mispredict, leave when the countdown hits zero.
   always_comb begin
      w_state_nxt      = r_state;
      w_shadow_cnt_nxt = r_shadow_cnt;
      case (r_state)
         ST_RUN: begin
            if (w_accept && w_mispredict) begin
               w_state_nxt      = ST_SHADOW;
               w_shadow_cnt_nxt = SHADOW_LOAD;
            end
         end
         ST_SHADOW: begin
            if (!freeze) begin
               w_shadow_cnt_nxt = r_shadow_cnt - 4'd1;
               if (r_shadow_cnt == 4'd1) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         default: begin
            w_state_nxt      = ST_RUN;
            w_shadow_cnt_nxt = 4'd0;
         end
      endcase
   end

   // Pulses are plain registered accept terms, so freeze cannot stretch them.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         update_btb    <= 1'b0;
         misprediction <= 1'b0;
      end else begin
         update_btb    <= w_accept;
         misprediction <= w_accept && w_mispredict;
      end
   end

   // Payload registers hold their last loaded value between pulses.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         branch_outcome    <= 1'b0;
         predicted_outcome <= 1'b0;
         update_pc         <= '0;
         branch_target     <= '0;
         correct_pc        <= '0;
      end else if (w_accept) begin
         branch_outcome    <= w_actual_taken;
         predicted_outcome <= ex_pred_taken;
         update_pc         <= ex_pc;
         branch_target     <= ex_target;
         correct_pc        <= w_actual_next;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (w_accept && (branch_cnt != '1)) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
         end
         if (w_accept && w_mispredict && (mispred_cnt != '1)) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter WORD_W, default 32: width of all PC/target/address buses.
REQ-002 Parameter SHADOW_CYCLES, default 2: count of non-frozen cycles after a misprediction during which resolutions are squashed; legal range 1..15.
REQ-003 Parameter CNT_W, default 32: width of each performance counter.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, asynchronous, active-low.
REQ-006 ex_valid  input  1  execute stage presents a resolved branch or jump this cycle.
REQ-007 ex_is_jump  input  1  resolved instruction is an unconditional jump; treated as taken.
REQ-008 ex_pc  input  WORD_W  PC of the resolved instruction.
REQ-009 ex_target  input  WORD_W  computed taken target.
REQ-010 ex_taken  input  1  actual conditional outcome; ignored when ex_is_jump=1.
REQ-011 ex_pred_taken  input  1  direction predicted at fetch.
REQ-012 ex_pred_pc  input  WORD_W  next PC fetch actually used after this instruction.
REQ-013 freeze  input  1  pipeline stall; blocks acceptance and shadow countdown.
REQ-014 update_btb  output  1  one-cycle pulse: BTB/predictor write for the resolved branch.
REQ-015 branch_outcome  output  1  actual direction of the resolved branch, valid with update_btb.
REQ-016 predicted_outcome  output  1  registered ex_pred_taken, valid with update_btb.
REQ-017 update_pc  output  WORD_W  PC of the resolved branch, valid with update_btb.
REQ-018 branch_target  output  WORD_W  taken target of the resolved branch, valid with update_btb.
REQ-019 misprediction  output  1  one-cycle pulse: fetch shall redirect to correct_pc.
REQ-020 correct_pc  output  WORD_W  architecturally correct next PC, valid with misprediction.
REQ-021 branch_cnt  output  CNT_W  accepted resolutions since reset.
REQ-022 mispred_cnt  output  CNT_W  accepted mispredictions since reset.

Function
REQ-023 Acceptance: ex_valid=1 AND freeze=0 AND state=RUN; otherwise inputs ignored entirely.
REQ-024 actual_taken = ex_is_jump OR ex_taken; actual_next = actual_taken ? ex_target : ex_pc+4, modulo 2^WORD_W (0xFFFFFFFC+4 = 0x0).
REQ-025 Mispredict = (actual_next != ex_pred_pc); direction match with wrong target is still a mispredict.
REQ-026 Latency: all outputs for an accepted resolution appear exactly one cycle after the accepting edge.
REQ-027 update_btb pulses for every accepted resolution; misprediction pulses only when mispredict.
REQ-028 Pulses last exactly one cycle and are not extended or suppressed by freeze in the output cycle.
REQ-029 update_pc, branch_target, branch_outcome, predicted_outcome, correct_pc hold last loaded values between pulses.
REQ-030 States: RUN, SHADOW. RUN->SHADOW on accepted mispredict, loading shadow counter with SHADOW_CYCLES.
REQ-031 In SHADOW: counter decrements on each cycle with freeze=0; ex_valid ignored (squashed wrong-path); return to RUN on edge where counter goes 1->0.
REQ-032 ex_valid on the RUN-return cycle's following cycle is accepted normally; no back-to-back misprediction pulses possible.
REQ-033 branch_cnt increments by 1 on each acceptance; mispred_cnt by 1 on each accepted mispredict; both saturate at all-ones.
REQ-034 Counters update on the same edge as the output registers.

Reset
REQ-035 nRST low asynchronously forces: state=RUN, shadow counter=0, update_btb=0, misprediction=0, branch_outcome=0, predicted_outcome=0, update_pc=0, branch_target=0, correct_pc=0, branch_cnt=0, mispred_cnt=0.
REQ-036 Reset during SHADOW or during a pulse cycle aborts it; first edge after release with ex_valid=1, freeze=0 is accepted.

Verification
REQ-037 Correct not-taken: ex_pc=0x100, ex_taken=0, ex_pred_taken=0, ex_pred_pc=0x104 -> next cycle update_btb=1, branch_outcome=0, update_pc=0x100, misprediction=0, branch_cnt=1.
REQ-038 Wrong direction: ex_pc=0x200, ex_target=0x80, ex_taken=1, ex_pred_pc=0x204 -> next cycle misprediction=1, correct_pc=0x80, mispred_cnt=1; ex_valid held high next 2 cycles -> ignored, branch_cnt stays 1; third cycle accepted.
REQ-039 Wrong target jump: ex_is_jump=1, ex_taken=0, ex_target=0x400, ex_pred_pc=0x300 -> misprediction=1, branch_outcome=1, correct_pc=0x400.
REQ-040 Freeze: ex_valid=1, freeze=1 for 3 cycles -> no pulses, counters unchanged; freeze in SHADOW for 4 cycles extends squash window by 4 cycles.
REQ-041 Wrap: ex_pc=0xFFFFFFFC, not taken, ex_pred_pc=0x0 -> no misprediction; ex_pred_pc=0xFFFFFFFC+... any other value -> misprediction with correct_pc=0x0.
REQ-042 Async reset asserted mid-SHADOW between edges -> all outputs 0 immediately; ex_valid on first post-release edge accepted.
